// File: rtl/mips_pkg.sv
// Shared MIPS core definitions.
// Fetch-stage PC defaults, state and next-PC select encodings.
package mips_pkg;

  localparam logic [31:0] RESET_VEC_D = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_D   = 32'h0000_4180;
  localparam int          INC_D       = 4;

  typedef enum logic {
    RUN,
    PEND
  } pcg_state_t;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_REDIR,
    SEL_PEND,
    SEL_EPC,
    SEL_EXC
  } pc_sel_t;

endpackage

// File: rtl/pc_gen_if.sv
// Control-flow request and fetch-PC bundle
// between hazard/branch/CP0 logic and pc_gen.
interface pc_gen_if #(
  parameter int WIDTH = 32
);

  logic             stall_i;
  logic             br_taken_i;
  logic [WIDTH-1:0] br_target_i;
  logic             jump_i;
  logic [WIDTH-1:0] jump_target_i;
  logic             exc_i;
  logic             eret_i;
  logic [WIDTH-1:0] epc_i;
  logic [WIDTH-1:0] pc_o;
  logic [WIDTH-1:0] pc_plus4_o;
  logic [WIDTH-1:0] pc_plus8_o;
  logic             adel_o;
  logic             pend_o;

  modport master (
    output stall_i, br_taken_i, br_target_i,
    output jump_i, jump_target_i,
    output exc_i, eret_i, epc_i,
    input  pc_o, pc_plus4_o, pc_plus8_o,
    input  adel_o, pend_o
  );

  modport slave (
    input  stall_i, br_taken_i, br_target_i,
    input  jump_i, jump_target_i,
    input  exc_i, eret_i, epc_i,
    output pc_o, pc_plus4_o, pc_plus8_o,
    output adel_o, pend_o
  );

endinterface

// File: rtl/pc_next_mux.sv
// Priority select of the next fetch PC:
// exception > eret > pending/live redirect > sequential.
module pc_next_mux
  import mips_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter logic [31:0] EXC_VEC = EXC_VEC_D,
  parameter int          INC     = INC_D
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             pend,
  input  logic [WIDTH-1:0] pend_tgt,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic             live,
  output logic [WIDTH-1:0] live_tgt,
  output logic             pc_we,
  output pc_sel_t          sel,
  output logic [WIDTH-1:0] next_pc
);

  assign live     = br_taken | jump;
  assign live_tgt = br_taken ? br_target : jump_target;

  always_comb begin
    pc_we   = 1'b1;
    sel     = SEL_SEQ;
    next_pc = pc;
    priority case (1'b1)
      exc: begin
        sel     = SEL_EXC;
        next_pc = WIDTH'(EXC_VEC);
      end
      eret: begin
        sel     = SEL_EPC;
        next_pc = epc;
      end
      stall: begin
        pc_we = 1'b0;
      end
      pend: begin
        sel     = SEL_PEND;
        next_pc = pend_tgt;
      end
      live: begin
        sel     = SEL_REDIR;
        next_pc = live_tgt;
      end
      default: begin
        next_pc = pc + WIDTH'(INC);
      end
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with stall-safe redirect buffer.
// A redirect seen during a stall is held until the stall drops.
module pc_gen
  import mips_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = RESET_VEC_D,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_D,
  parameter int          INC       = INC_D
) (
  input logic    clk,
  input logic    reset,
  pc_gen_if.slave bus
);

  pcg_state_t       state_q, state_d;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] live_tgt;
  logic             live;
  logic             pc_we;
  pc_sel_t          sel;

  pc_next_mux #(
    .WIDTH   (WIDTH),
    .EXC_VEC (EXC_VEC),
    .INC     (INC)
  ) u_mux (
    .pc          (pc_q),
    .pend        (state_q == PEND),
    .pend_tgt    (pend_q),
    .stall       (bus.stall_i),
    .br_taken    (bus.br_taken_i),
    .br_target   (bus.br_target_i),
    .jump        (bus.jump_i),
    .jump_target (bus.jump_target_i),
    .exc         (bus.exc_i),
    .eret        (bus.eret_i),
    .epc         (bus.epc_i),
    .live        (live),
    .live_tgt    (live_tgt),
    .pc_we       (pc_we),
    .sel         (sel),
    .next_pc     (next_pc)
  );

  // Only the first redirect captured during a stall is kept.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (sel inside {SEL_EXC, SEL_EPC, SEL_PEND}) begin
      state_d = RUN;
    end else if (state_q == RUN && bus.stall_i && live) begin
      state_d = PEND;
      pend_d  = live_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pend_q  <= '0;
      pc_q    <= WIDTH'(RESET_VEC);
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (pc_we) pc_q <= next_pc;
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.pc_plus4_o = pc_q + WIDTH'(INC);
  assign bus.pc_plus8_o = pc_q + WIDTH'(2 * INC);
  assign bus.adel_o     = |pc_q[1:0];
  assign bus.pend_o     = (state_q == PEND);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen.
// Expected PC/pend pushed per step, popped after the edge.
module tb_pc_gen;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];

  pc_gen_if #(.WIDTH(32)) bus ();

  pc_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic clr();
    bus.stall_i       = 1'b0;
    bus.br_taken_i    = 1'b0;
    bus.br_target_i   = '0;
    bus.jump_i        = 1'b0;
    bus.jump_target_i = '0;
    bus.exc_i         = 1'b0;
    bus.eret_i        = 1'b0;
    bus.epc_i         = '0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [31:0] pc,
                      input logic pend);
    exp_t e;
    exp_t x;
    e.pc   = pc;
    e.pend = pend;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("pc", bus.pc_o, x.pc);
    chk("pend", {31'd0, bus.pend_o}, {31'd0, x.pend});
    chk("plus4", bus.pc_plus4_o, x.pc + 32'd4);
    chk("plus8", bus.pc_plus8_o, x.pc + 32'd8);
    chk("adel", {31'd0, bus.adel_o}, {31'd0, |x.pc[1:0]});
  endtask

  initial begin
    reset = 1'b1;
    clr();
    tick(32'h3000, 1'b0);
    reset = 1'b0;
    tick(32'h3004, 1'b0);
    tick(32'h3008, 1'b0);
    tick(32'h300C, 1'b0);
    tick(32'h3010, 1'b0);
    // branch taken
    bus.br_taken_i  = 1'b1;
    bus.br_target_i = 32'h3100;
    tick(32'h3100, 1'b0);
    clr();
    bus.jump_i        = 1'b1;
    bus.jump_target_i = 32'h3010;
    tick(32'h3010, 1'b0);
    // redirect captured under stall
    bus.stall_i       = 1'b1;
    bus.jump_target_i = 32'h3200;
    tick(32'h3010, 1'b1);
    clr();
    bus.stall_i     = 1'b1;
    bus.br_taken_i  = 1'b1;
    bus.br_target_i = 32'h3300;
    tick(32'h3010, 1'b1);
    clr();
    bus.stall_i = 1'b1;
    tick(32'h3010, 1'b1);
    clr();
    bus.jump_i        = 1'b1;
    bus.jump_target_i = 32'h3400;
    tick(32'h3200, 1'b0);
    // exception while pending
    clr();
    bus.stall_i       = 1'b1;
    bus.jump_i        = 1'b1;
    bus.jump_target_i = 32'h3500;
    tick(32'h3200, 1'b1);
    clr();
    bus.stall_i = 1'b1;
    bus.exc_i   = 1'b1;
    tick(32'h4180, 1'b0);
    clr();
    tick(32'h4184, 1'b0);
    bus.eret_i  = 1'b1;
    bus.epc_i   = 32'h3044;
    bus.stall_i = 1'b1;
    tick(32'h3044, 1'b0);
    clr();
    bus.br_taken_i    = 1'b1;
    bus.br_target_i   = 32'h3100;
    bus.jump_i        = 1'b1;
    bus.jump_target_i = 32'h3200;
    tick(32'h3100, 1'b0);
    // wrap and misalignment
    clr();
    bus.jump_i        = 1'b1;
    bus.jump_target_i = 32'hFFFF_FFFC;
    tick(32'hFFFF_FFFC, 1'b0);
    clr();
    tick(32'h0000_0000, 1'b0);
    bus.jump_i        = 1'b1;
    bus.jump_target_i = 32'h3102;
    tick(32'h3102, 1'b0);
    clr();
    bus.stall_i       = 1'b1;
    bus.jump_i        = 1'b1;
    bus.jump_target_i = 32'h3300;
    tick(32'h3102, 1'b1);
    reset = 1'b1;
    tick(32'h3000, 1'b0);
    reset = 1'b0;
    clr();
    tick(32'h3004, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Fetch-stage program counter generator for the pipelined MIPS core. It holds the architectural fetch PC and selects the next PC from sequential, branch, jump, exception-vector and ERET sources by fixed priority. It honours pipeline stalls, and it buffers any control-flow redirect that arrives while the PC is stalled, so the redirect is never lost. It sits between the hazard unit / decode-stage branch logic / CP0 and the instruction memory address port.

Parameters:
WIDTH, 32, PC and target width in bits (≥ 8)
RESET_VEC, 32'h0000_3000, PC value after reset (truncated to WIDTH)
EXC_VEC, 32'h0000_4180, exception handler entry address
INC, 4, sequential increment in bytes

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall_i  in  1  hazard stall; PC holds when 1
br_taken_i  in  1  decode-stage branch resolved taken
br_target_i  in  WIDTH  branch target address
jump_i  in  1  jump (j/jal/jr/jalr) request
jump_target_i  in  WIDTH  jump target address
exc_i  in  1  exception/interrupt taken (from CP0)
eret_i  in  1  ERET executing
epc_i  in  WIDTH  return address from CP0
pc_o  out  WIDTH  current fetch PC (registered)
pc_plus4_o  out  WIDTH  pc_o + INC
pc_plus8_o  out  WIDTH  pc_o + 2*INC (link address)
adel_o  out  1  fetch misalignment: pc_o[1:0] != 0
pend_o  out  1  a redirect is buffered (state PEND)

Behaviour:
- Reset is synchronous: pc_o = RESET_VEC, state = RUN, pending target = 0, pend_o = 0. Reset overrides every other input.
- All arithmetic wraps modulo 2^WIDTH. pc_plus4_o, pc_plus8_o and adel_o are combinational from pc_o.
- Priority each cycle: exc_i > eret_i > redirect (pending or live) > sequential.
- exc_i=1: pc ← EXC_VEC next edge, regardless of stall_i. State → RUN and any pending redirect is discarded.
- eret_i=1 (exc_i=0): pc ← epc_i next edge, regardless of stall_i. Pending redirect is discarded; state → RUN.
- Live redirect target: br_target_i if br_taken_i, else jump_target_i if jump_i. If both are asserted, branch wins.
- State RUN, no exc/eret:
  - stall_i=0 and live redirect: pc ← target.
  - stall_i=0 and no redirect: pc ← pc + INC.
  - stall_i=1 and live redirect: pc holds, target is latched into the pending register, state → PEND.
  - stall_i=1 and no redirect: pc holds.
- State PEND, no exc/eret:
  - stall_i=1: pc holds. The pending target is unchanged; the first captured redirect wins and later live redirects are ignored.
  - stall_i=0: pc ← pending target, state → RUN. A live redirect in this same cycle is ignored.
- A redirect never produces a cycle at pc + INC between capture and application.
- Latency: every PC update is visible on pc_o one cycle after the qualifying edge. There is no combinational path from inputs to pc_o.
- A misaligned target is loaded as-is. adel_o flags it and CP0 handles the fault; this block raises no exception itself.

Decomposition:
- Shared package mips_pkg holds:
  - RESET_VEC and EXC_VEC defaults
  - the INC constant
  - the state encoding typedef pcg_state_t {RUN, PEND}
  - the next-PC source select enum {SEL_SEQ, SEL_REDIR, SEL_PEND, SEL_EPC, SEL_EXC}
- One natural sub-module is pc_next_mux: a purely combinational priority select that produces the next PC and the select code. The register, FSM and pending buffer live in pc_gen.

Test Plan:
- Reset, then 3 free cycles → pc_o = 0x3000, 0x3004, 0x3008, 0x300C; pc_plus8_o = 0x3014 at the last cycle; pend_o = 0.
- At pc 0x3010, br_taken_i=1, target 0x3100, stall_i=0 → next pc_o = 0x3100.
- At pc 0x3010, stall_i=1 for 3 cycles, jump_i=1 target 0x3200 in the first stalled cycle only → pc_o stays 0x3010, pend_o=1 for 3 cycles; first unstalled cycle → pc_o = 0x3200, pend_o = 0.
- In PEND (target 0x3200) with stall_i=1, assert exc_i → next pc_o = 0x4180, pend_o = 0; after release, pc_o continues 0x4184 (not 0x3200).
- eret_i=1, epc_i=0x3044, stall_i=1 → next pc_o = 0x3044. Branch and jump asserted together (0x3100 / 0x3200) → next pc_o = 0x3100.
- WIDTH=32, pc forced near 0xFFFF_FFFC via jump → next sequential pc_o = 0x0000_0000. Jump to 0x3102 → adel_o = 1. Reset asserted mid-PEND → pc_o = 0x3000, pend_o = 0.
